wired_cdb_sched: RTL and testbench

WIRED_CDB_SCHED -- requirements
Module: wired_cdb_sched

---
 rtl/wired_cdb_sched.sv | 108 ++++++++++
 tb/tb_wired_cdb_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wired_cdb_sched.sv
// wired_cdb_sched -- two-lane common data bus scheduler.
//
// Each result source targets one of two CDB lanes, chosen by bit 0 of its
// destination ROB id (the ROB bank). Every lane runs its own round-robin
// arbiter, so up to two results are accepted per cycle: at most one per lane.
// Granted results are registered and broadcast for exactly one cycle.
//
// Handshake: a source asserts src_valid_i[i] and must hold valid, wid and
// data stable until the cycle in which src_ready_o[i]=1. That cycle is the
// transfer. src_ready_o is combinational, and the CDB never back-pressures.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset, has priority over flush_i
//   flush_i      : pipeline flush, blocks all grants while high
//   src_valid_i  : per-source result present
//   src_ready_o  : per-source grant (transfer this cycle)
//   src_wid_i    : per-source destination ROB id, bit 0 selects the lane
//   src_wdata_i  : per-source result data
//   cdb_valid_o  : per-lane broadcast valid (one-cycle pulse)
//   cdb_wid_o    : per-lane broadcast ROB id (holds when not valid)
//   cdb_wdata_o  : per-lane broadcast data (holds when not valid)
module wired_cdb_sched #(
    parameter int CDB_PORT_CNT = 5,
    parameter int ROB_LEN      = 6,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush_i,
    input  logic [CDB_PORT_CNT-1:0]                 src_valid_i,
    output logic [CDB_PORT_CNT-1:0]                 src_ready_o,
    input  logic [CDB_PORT_CNT-1:0][ROB_LEN-1:0]    src_wid_i,
    input  logic [CDB_PORT_CNT-1:0][DATA_WIDTH-1:0] src_wdata_i,
    output logic [1:0]                              cdb_valid_o,
    output logic [1:0][ROB_LEN-1:0]                 cdb_wid_o,
    output logic [1:0][DATA_WIDTH-1:0]              cdb_wdata_o
);

    localparam int PTR_W = $clog2(CDB_PORT_CNT);

    logic [1:0][PTR_W-1:0]      rr_q;
    logic [1:0][PTR_W-1:0]      rr_d;
    logic [1:0]                 gnt_valid;
    logic [1:0][PTR_W-1:0]      gnt_idx;
    logic [1:0][ROB_LEN-1:0]    gnt_wid;
    logic [1:0][DATA_WIDTH-1:0] gnt_data;
    logic [PTR_W:0]             cand_sum;
    logic [PTR_W-1:0]           cand_idx;

    // Per-lane round-robin search: scan from rr_q[k] upward, wrapping at
    // CDB_PORT_CNT-1. The extra sum bit absorbs rr_q + offset before the
    // wrap. Rst and flush suppress every grant, which also freezes rr_q.
    always_comb begin
        src_ready_o = '0;
        gnt_valid   = '0;
        gnt_idx     = '0;
        gnt_wid     = '0;
        gnt_data    = '0;
        rr_d        = rr_q;
        cand_sum    = '0;
        cand_idx    = '0;
        if (!rst && !flush_i) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < CDB_PORT_CNT; j++) begin
                    cand_sum = {1'b0, rr_q[k]} + (PTR_W+1)'(j);
                    if (cand_sum >= (PTR_W+1)'(CDB_PORT_CNT)) begin
                        cand_sum = cand_sum - (PTR_W+1)'(CDB_PORT_CNT);
                    end
                    cand_idx = cand_sum[PTR_W-1:0];
                    if (!gnt_valid[k] && src_valid_i[cand_idx] &&
                        (src_wid_i[cand_idx][0] == 1'(k))) begin
                        gnt_valid[k]          = 1'b1;
                        gnt_idx[k]            = cand_idx;
                        gnt_wid[k]            = src_wid_i[cand_idx];
                        gnt_data[k]           = src_wdata_i[cand_idx];
                        src_ready_o[cand_idx] = 1'b1;
                    end
                end
                if (gnt_valid[k]) begin
                    rr_d[k] = (gnt_idx[k] == PTR_W'(CDB_PORT_CNT-1)) ?
                              '0 : gnt_idx[k] + 1'b1;
                end
            end
        end
    end

    // Lane registers: valid is a single-cycle pulse; id and data only load
    // on a grant so they hold their last broadcast otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            cdb_valid_o <= '0;
            cdb_wid_o   <= '0;
            cdb_wdata_o <= '0;
        end else begin
            rr_q        <= rr_d;
            cdb_valid_o <= gnt_valid;
            for (int k = 0; k < 2; k++) begin
                if (gnt_valid[k]) begin
                    cdb_wid_o[k]   <= gnt_wid[k];
                    cdb_wdata_o[k] <= gnt_data[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_wired_cdb_sched.sv
// Directed bench for wired_cdb_sched. The driver issues one vector per cycle
// with a hand-computed grant pattern and queues the broadcast each grant
// must produce (tagged with the cycle it is due). A negedge monitor pops and
// compares whatever each lane broadcasts.
module tb_wired_cdb_sched;
    localparam int N  = 5;
    localparam int RL = 6;
    localparam int DW = 32;
    localparam int W  = 32 + RL + DW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush_i = 1'b0;
    logic [N-1:0]           src_valid = '0;
    logic [N-1:0]           src_ready;
    logic [N-1:0][RL-1:0]   src_wid = '0;
    logic [N-1:0][DW-1:0]   src_wdata = '0;
    logic [1:0]             cdb_valid;
    logic [1:0][RL-1:0]     cdb_wid;
    logic [1:0][DW-1:0]     cdb_wdata;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    wired_cdb_sched #(.CDB_PORT_CNT(N), .ROB_LEN(RL), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .src_valid_i(src_valid), .src_ready_o(src_ready),
        .src_wid_i(src_wid), .src_wdata_i(src_wdata),
        .cdb_valid_o(cdb_valid), .cdb_wid_o(cdb_wid), .cdb_wdata_o(cdb_wdata)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: one lane per call, entries are {due cycle, wid, data}
    task automatic mon_lane(input int k);
        logic [W-1:0] a;
        logic [W-1:0] e;
        int           n;
        a = {32'(cyc), cdb_wid[k], cdb_wdata[k]};
        n = (k == 0) ? exp_q0.size() : exp_q1.size();
        if (cdb_valid[k]) begin
            if (n == 0) begin
                total++;
                bad++;
                $display("FAIL lane%0d_unexpected: got %h expected no broadcast", k, a);
            end else begin
                if (k == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                chk($sformatf("lane%0d_bcast", k), a, e);
            end
        end else if (n != 0) begin
            e = (k == 0) ? exp_q0[0] : exp_q1[0];
            if (int'(e[W-1 -: 32]) <= cyc) begin
                if (k == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
                total++;
                bad++;
                $display("FAIL lane%0d_missing: got no broadcast expected %h", k, e);
            end
        end
    endtask

    always @(negedge clk) begin
        mon_lane(0);
        mon_lane(1);
    end

    // driver: one cycle of stimulus with the hand-computed grant vector
    task automatic drive(input logic [N-1:0] v, input logic f, input logic [N-1:0] exp_rdy);
        logic [W-1:0] e;
        src_valid = v;
        flush_i   = f;
        @(negedge clk);
        chk("src_ready", W'(src_ready), W'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                e = {32'(cyc + 1), src_wid[i], src_wdata[i]};
                if (src_wid[i][0]) exp_q1.push_back(e);
                else               exp_q0.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with all sources requesting: nothing may be granted
        src_wid   = {6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        src_valid = '1;
        repeat (2) @(negedge clk);
        chk("rst_ready", W'(src_ready), W'(0));
        chk("rst_valid", W'(cdb_valid), W'(0));
        chk("rst_wid", W'(cdb_wid), W'(0));
        chk("rst_data", W'(cdb_wdata), W'(0));
        chk("rst_rr", W'(dut.rr_q), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_valid = '0;

        // single grant on lane 1
        src_wid[2] = 6'h0B; src_wdata[2] = 32'hDEAD_BEEF;
        drive(5'b00100, 1'b0, 5'b00100);
        chk("rr1_after_src2", W'(dut.rr_q[1]), W'(3));
        drive(5'b00000, 1'b0, 5'b00000);
        chk("idle_valid", W'(cdb_valid), W'(0));
        chk("hold_wid1", W'(cdb_wid[1]), W'(6'h0B));
        chk("hold_data1", W'(cdb_wdata[1]), W'(32'hDEAD_BEEF));

        // one grant on each lane in the same cycle
        src_wid[0] = 6'h04; src_wdata[0] = 32'h0000_00A0;
        src_wid[1] = 6'h07; src_wdata[1] = 32'h0000_00A1;
        drive(5'b00011, 1'b0, 5'b00011);

        // move lane 0 pointer from 1 to 0 via a grant to source 4
        src_wid[4] = 6'h08; src_wdata[4] = 32'h0000_00A4;
        drive(5'b10000, 1'b0, 5'b10000);
        chk("rr0_wrap", W'(dut.rr_q[0]), W'(0));

        // sources 0, 3, 4 held on lane 0: order 0, 3, 4, 0
        src_wid[0] = 6'h00; src_wdata[0] = 32'h0000_00B0;
        src_wid[3] = 6'h0C; src_wdata[3] = 32'h0000_00B3;
        drive(5'b11001, 1'b0, 5'b00001);
        drive(5'b11001, 1'b0, 5'b01000);
        drive(5'b11001, 1'b0, 5'b10000);
        drive(5'b11001, 1'b0, 5'b00001);
        chk("rr0_after_rr", W'(dut.rr_q[0]), W'(1));

        // flush blocks grants and freezes pointers
        src_wid[1] = 6'h02; src_wdata[1] = 32'h0000_00C1;
        src_wid[2] = 6'h04; src_wdata[2] = 32'h0000_00C2;
        drive(5'b00110, 1'b1, 5'b00000);
        chk("flush_valid", W'(cdb_valid), W'(0));
        chk("flush_rr0", W'(dut.rr_q[0]), W'(1));
        drive(5'b00110, 1'b0, 5'b00010);
        drive(5'b00110, 1'b0, 5'b00100);

        // all sources valid, both lanes busy with wrap on both
        src_wid   = {6'h06, 6'h02, 6'h05, 6'h03, 6'h01};
        src_wdata = {32'hD4, 32'hD3, 32'hD2, 32'hD1, 32'hD0};
        drive(5'b11111, 1'b0, 5'b01100);
        drive(5'b11111, 1'b0, 5'b10001);
        drive(5'b11111, 1'b0, 5'b01010);

        // continuous traffic with a one-cycle reset pulse
        src_wid[1] = 6'h0A; src_wdata[1] = 32'h0000_00E1;
        src_wid[3] = 6'h0E; src_wdata[3] = 32'h0000_00E3;
        drive(5'b01010, 1'b0, 5'b00010);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", W'(src_ready), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", W'(cdb_valid), W'(0));
        chk("midrst_rr", W'(dut.rr_q), W'(0));
        chk("midrst_wid", W'(cdb_wid), W'(0));
        drive(5'b01010, 1'b0, 5'b00010);

        repeat (3) drive(5'b00000, 1'b0, 5'b00000);
        chk("q0_drained", W'(exp_q0.size()), W'(0));
        chk("q1_drained", W'(exp_q1.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
